// File: rtl/ex_mm_wb_pipe_pkg.sv
// Shared widths, stage record types and the MM bubble constant for the EX->MM->WB pipe.
package ex_mm_wb_pipe_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int REG_AW_DEF = 3;

    typedef struct packed {
        logic [REG_AW_DEF-1:0] rd;
        logic                  wb;
        logic                  mem_rd;
        logic                  mem_wr;
        logic [DATA_W_DEF-1:0] alu;
        logic [DATA_W_DEF-1:0] st_data;
    } mm_stage_t;

    typedef struct packed {
        logic [REG_AW_DEF-1:0] rd;
        logic                  wb;
        logic [DATA_W_DEF-1:0] wdata;
    } wb_stage_t;

    localparam mm_stage_t MM_BUBBLE = '0;

endpackage

// File: rtl/ex_mm_wb_pipe_pipe_reg_stage.sv
// Generic pipeline register: async active-low clear, stall holds, flush loads BUBBLE.
module pipe_reg_stage #(
    parameter int           W      = 8,
    parameter logic [W-1:0] BUBBLE = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall_i,
    input  logic         flush_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (!stall_i) begin
            data_d = flush_i ? BUBBLE : d_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/ex_mm_wb_pipe.sv
// MM and WB stage registers with retire counter.
// Optional macro LOAD_USE_DET_EN adds rs_Id/rt_Id inputs and the load_use_hz output.
module ex_mm_wb_pipe
    import ex_mm_wb_pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush_Ex,
    input  logic [REG_AW-1:0] rd_Ex,
    input  logic              WB_Ex,
    input  logic              mem_rd_Ex,
    input  logic              mem_wr_Ex,
    input  logic [DATA_W-1:0] alu_Ex,
    input  logic [DATA_W-1:0] st_data_Ex,
    input  logic [DATA_W-1:0] rdata_MM,
    output logic [REG_AW-1:0] rd_MM,
    output logic              WB_MM,
    output logic [DATA_W-1:0] alu_MM,
    output logic [DATA_W-1:0] st_data_MM,
    output logic              mem_rd_MM,
    output logic              mem_wr_MM,
    output logic [REG_AW-1:0] rd_WB,
    output logic              WB_WB,
    output logic [DATA_W-1:0] wdata_WB,
`ifdef LOAD_USE_DET_EN
    input  logic [REG_AW-1:0] rs_Id,
    input  logic [REG_AW-1:0] rt_Id,
    output logic              load_use_hz,
`endif
    output logic [15:0]       retire_cnt
);

    mm_stage_t   mm_d;
    mm_stage_t   mm_q;
    wb_stage_t   wb_d;
    wb_stage_t   wb_q;
    logic [15:0] retire_cnt_q;
    logic [15:0] retire_cnt_d;

    // Writes to r0 are dropped here so forwarding never sees them; load wins an illegal rd+wr.
    always_comb begin
        mm_d         = MM_BUBBLE;
        mm_d.rd      = rd_Ex;
        mm_d.wb      = WB_Ex && (rd_Ex != '0);
        mm_d.mem_rd  = mem_rd_Ex;
        mm_d.mem_wr  = mem_wr_Ex && !mem_rd_Ex;
        mm_d.alu     = alu_Ex;
        mm_d.st_data = st_data_Ex;
    end

    always_comb begin
        wb_d       = '0;
        wb_d.rd    = mm_q.rd;
        wb_d.wb    = mm_q.wb;
        wb_d.wdata = mm_q.mem_rd ? rdata_MM : mm_q.alu;
    end

    pipe_reg_stage #(
        .W      ($bits(mm_stage_t)),
        .BUBBLE (MM_BUBBLE)
    ) u_mm_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .stall_i (stall),
        .flush_i (flush_Ex),
        .d_i     (mm_d),
        .q_o     (mm_q)
    );

    pipe_reg_stage #(
        .W      ($bits(wb_stage_t)),
        .BUBBLE ('0)
    ) u_wb_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .stall_i (stall),
        .flush_i (1'b0),
        .d_i     (wb_d),
        .q_o     (wb_q)
    );

    // Counted on the edge that moves a writing instruction into WB, so it tracks WB_WB.
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (!stall && wb_d.wb && (retire_cnt_q != 16'hFFFF)) begin
            retire_cnt_d = retire_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

`ifdef LOAD_USE_DET_EN
    assign load_use_hz = mem_rd_Ex && WB_Ex && (rd_Ex != '0) &&
                         ((rd_Ex == rs_Id) || (rd_Ex == rt_Id));
`endif

    assign rd_MM      = mm_q.rd;
    assign WB_MM      = mm_q.wb;
    assign alu_MM     = mm_q.alu;
    assign st_data_MM = mm_q.st_data;
    assign mem_rd_MM  = mm_q.mem_rd;
    assign mem_wr_MM  = mm_q.mem_wr;
    assign rd_WB      = wb_q.rd;
    assign WB_WB      = wb_q.wb;
    assign wdata_WB   = wb_q.wdata;
    assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_ex_mm_wb_pipe.sv
// Directed bench for ex_mm_wb_pipe with hand-computed expectations.
module tb_ex_mm_wb_pipe;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush_Ex;
    logic [2:0]  rd_Ex;
    logic        WB_Ex;
    logic        mem_rd_Ex;
    logic        mem_wr_Ex;
    logic [15:0] alu_Ex;
    logic [15:0] st_data_Ex;
    logic [15:0] rdata_MM;
    logic [2:0]  rd_MM;
    logic        WB_MM;
    logic [15:0] alu_MM;
    logic [15:0] st_data_MM;
    logic        mem_rd_MM;
    logic        mem_wr_MM;
    logic [2:0]  rd_WB;
    logic        WB_WB;
    logic [15:0] wdata_WB;
    logic [15:0] retire_cnt;
`ifdef LOAD_USE_DET_EN
    logic [2:0]  rs_Id;
    logic [2:0]  rt_Id;
    logic        load_use_hz;
`endif

    int checks;
    int errors;

    ex_mm_wb_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .flush_Ex   (flush_Ex),
        .rd_Ex      (rd_Ex),
        .WB_Ex      (WB_Ex),
        .mem_rd_Ex  (mem_rd_Ex),
        .mem_wr_Ex  (mem_wr_Ex),
        .alu_Ex     (alu_Ex),
        .st_data_Ex (st_data_Ex),
        .rdata_MM   (rdata_MM),
        .rd_MM      (rd_MM),
        .WB_MM      (WB_MM),
        .alu_MM     (alu_MM),
        .st_data_MM (st_data_MM),
        .mem_rd_MM  (mem_rd_MM),
        .mem_wr_MM  (mem_wr_MM),
        .rd_WB      (rd_WB),
        .WB_WB      (WB_WB),
        .wdata_WB   (wdata_WB),
`ifdef LOAD_USE_DET_EN
        .rs_Id      (rs_Id),
        .rt_Id      (rt_Id),
        .load_use_hz(load_use_hz),
`endif
        .retire_cnt (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] rd, input logic wb, input logic mrd,
                         input logic mwr, input logic [15:0] alu, input logic [15:0] sd);
        rd_Ex      = rd;
        WB_Ex      = wb;
        mem_rd_Ex  = mrd;
        mem_wr_Ex  = mwr;
        alu_Ex     = alu;
        st_data_Ex = sd;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mm"}, {13'd0, rd_MM, WB_MM, mem_rd_MM, mem_wr_MM, alu_MM}, 32'd0);
        check({tag, "_st"}, {16'd0, st_data_MM}, 32'd0);
        check({tag, "_wb"}, {12'd0, rd_WB, WB_WB, wdata_WB}, 32'd0);
        check({tag, "_cnt"}, {16'd0, retire_cnt}, 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        stall = 1'b0;
        flush_Ex = 1'b0;
        rdata_MM = 16'h0;
        drive(3'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
`ifdef LOAD_USE_DET_EN
        rs_Id = 3'd0;
        rt_Id = 3'd0;
`endif
        #2;
        check_all_zero("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU op to r3
        drive(3'd3, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h0);
        step();
        check("alu_rd_mm", rd_MM, 3'd3);
        check("alu_wb_mm", WB_MM, 1'b1);
        check("alu_alu_mm", alu_MM, 16'h1234);
        drive(3'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        step();
        check("alu_rd_wb", rd_WB, 3'd3);
        check("alu_wb_wb", WB_WB, 1'b1);
        check("alu_wdata", wdata_WB, 16'h1234);
        check("alu_cnt", retire_cnt, 16'd1);
        check("alu_bubble_mm", WB_MM, 1'b0);

        // load to r5
        drive(3'd5, 1'b1, 1'b1, 1'b0, 16'h0040, 16'h0);
        step();
        check("ld_mem_rd_mm", mem_rd_MM, 1'b1);
        check("ld_addr_mm", alu_MM, 16'h0040);
        rdata_MM = 16'hBEEF;
        drive(3'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        step();
        check("ld_wdata", wdata_WB, 16'hBEEF);
        check("ld_rd_wb", rd_WB, 3'd5);
        check("ld_cnt", retire_cnt, 16'd2);
        rdata_MM = 16'h0;

        // write to r0 is dropped
        drive(3'd0, 1'b1, 1'b0, 1'b0, 16'h5555, 16'h0);
        step();
        check("r0_wb_mm", WB_MM, 1'b0);
        check("r0_alu_mm", alu_MM, 16'h5555);
        drive(3'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        step();
        check("r0_wb_wb", WB_WB, 1'b0);
        check("r0_cnt", retire_cnt, 16'd2);

        // illegal load+store, then a plain store
        drive(3'd1, 1'b0, 1'b1, 1'b1, 16'h0010, 16'h1111);
        step();
        check("ill_mem_wr", mem_wr_MM, 1'b0);
        check("ill_mem_rd", mem_rd_MM, 1'b1);
        drive(3'd0, 1'b0, 1'b0, 1'b1, 16'h0020, 16'hA5A5);
        step();
        check("st_mem_wr", mem_wr_MM, 1'b1);
        check("st_data_mm", st_data_MM, 16'hA5A5);
        check("st_cnt", retire_cnt, 16'd2);

        // stall beats flush, then flush alone bubbles MM
        drive(3'd6, 1'b1, 1'b0, 1'b0, 16'h6666, 16'h0);
        step();
        stall = 1'b1;
        flush_Ex = 1'b1;
        drive(3'd7, 1'b1, 1'b0, 1'b0, 16'h7777, 16'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stl_rd_mm", rd_MM, 3'd6);
            check("stl_wb_mm", WB_MM, 1'b1);
            check("stl_alu_mm", alu_MM, 16'h6666);
            check("stl_mem_wr_wb", {rd_WB, WB_WB, wdata_WB}, {3'd0, 1'b0, 16'h0020});
            check("stl_cnt", retire_cnt, 16'd2);
        end
        stall = 1'b0;
        step();
        check("fl_wb_mm", WB_MM, 1'b0);
        check("fl_rd_mm", rd_MM, 3'd0);
        check("fl_alu_mm", alu_MM, 16'h0);
        check("fl_rd_wb", rd_WB, 3'd6);
        check("fl_wdata", wdata_WB, 16'h6666);
        check("fl_cnt", retire_cnt, 16'd3);
        flush_Ex = 1'b0;

        // async reset mid-stream discards in-flight work
        drive(3'd4, 1'b1, 1'b0, 1'b0, 16'h4444, 16'h0);
        step();
        check("pre_rst_wb_mm", WB_MM, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        drive(3'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        check("post_rst_wb_wb", WB_WB, 1'b0);
        check("post_rst_cnt", retire_cnt, 16'd0);

`ifdef LOAD_USE_DET_EN
        drive(3'd2, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0);
        rs_Id = 3'd2;
        rt_Id = 3'd0;
        #1;
        check("lu_hit", load_use_hz, 1'b1);
        rs_Id = 3'd4;
        rt_Id = 3'd1;
        #1;
        check("lu_miss", load_use_hz, 1'b0);
        rt_Id = 3'd2;
        #1;
        check("lu_hit_rt", load_use_hz, 1'b1);
        drive(3'd0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0);
        rs_Id = 3'd0;
        #1;
        check("lu_r0", load_use_hz, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_mm_wb_pipe.md
EX_MM_WB_PIPE -- requirements
Module: ex_mm_wb_pipe

Interface
- REQ-001: Parameter DATA_W, default 16, datapath width of ALU result, store data and write-back data.
- REQ-002: Parameter REG_AW, default 3, register-address width.
- REQ-003: clk  in  1  single clock; all state updates on rising edge.
- REQ-004: rst_n  in  1  asynchronous, active-low reset.
- REQ-005: stall  in  1  hold both stage registers unchanged.
- REQ-006: flush_Ex  in  1  replace the EX->MM transfer with a bubble.
- REQ-007: rd_Ex  in  REG_AW  destination register of the EX instruction.
- REQ-008: WB_Ex, mem_rd_Ex, mem_wr_Ex  in  1 each  write-back, load and store controls of the EX instruction.
- REQ-009: alu_Ex, st_data_Ex  in  DATA_W each  ALU result and store data from EX.
- REQ-010: rdata_MM  in  DATA_W  combinational data-memory read data for the MM-stage address.
- REQ-011: rd_MM, WB_MM  out  REG_AW, 1  MM-stage destination and qualified write enable (forwarding source).
- REQ-012: alu_MM, st_data_MM  out  DATA_W  memory address/ALU value and store data; mem_rd_MM, mem_wr_MM  out  1.
- REQ-013: rd_WB, WB_WB  out  REG_AW, 1  WB-stage destination and qualified write enable (forwarding source, register-file write).
- REQ-014: wdata_WB  out  DATA_W  register-file write data.
- REQ-015: retire_cnt  out  16  count of retired writing instructions.

Function
- REQ-016: Two register stages, MM and WB; one-cycle latency per stage; EX inputs appear on MM outputs one cycle after capture and on WB outputs two cycles after capture.
- REQ-017: WB_MM SHALL be captured as WB_Ex AND (rd_Ex != 0); a write to register 0 never asserts WB_MM or WB_WB.
- REQ-018: When stall=1, MM and WB registers and retire_cnt hold; stall has priority over flush_Ex.
- REQ-019: When flush_Ex=1 and stall=0, MM captures a bubble: WB_MM=0, mem_rd_MM=0, mem_wr_MM=0, rd_MM=0, data fields=0; WB advances normally.
- REQ-020: WB stage captures wdata_WB = rdata_MM when mem_rd_MM=1, else alu_MM; rd_WB=rd_MM, WB_WB=WB_MM.
- REQ-021: retire_cnt increments by 1 on each non-stalled edge where WB_WB=1, and saturates at 16'hFFFF.
- REQ-022: mem_rd_Ex and mem_wr_Ex both set is illegal; the block SHALL capture mem_wr=0 in that case (load wins).

Reset
- REQ-023: rst_n low SHALL clear all MM/WB registers and retire_cnt to 0 immediately, independent of clk.
- REQ-024: Reset asserted mid-operation discards in-flight instructions; no write-back occurs for them after release.
- REQ-025: The first capture occurs on the first rising edge with rst_n high.

Configuration
- REQ-026: Macro LOAD_USE_DET_EN; when defined, the block adds inputs rs_Id, rt_Id (REG_AW each) and output load_use_hz (1), combinationally = mem_rd_Ex AND WB_Ex AND (rd_Ex != 0) AND (rd_Ex==rs_Id OR rd_Ex==rt_Id).
- REQ-027: Without LOAD_USE_DET_EN, those ports do not exist, and the pipeline is otherwise identical.

Structure
- REQ-028: A shared package holds REG_AW/DATA_W defaults, the mm_stage_t and wb_stage_t record types, and the bubble constant.
- REQ-029: One sub-module, pipe_reg_stage, a generic width-parameterised register with stall/flush/async reset, instantiated for MM and WB.

Verification
- REQ-030: Reset: rst_n=0 mid-stream -> all outputs 0 within the same cycle; retire_cnt=0.
- REQ-031: ALU op rd_Ex=3, WB_Ex=1, alu_Ex=16'h1234 -> cycle+1 rd_MM=3, WB_MM=1; cycle+2 rd_WB=3, WB_WB=1, wdata_WB=16'h1234, retire_cnt=1.
- REQ-032: Load rd_Ex=5, mem_rd_Ex=1, rdata_MM=16'hBEEF -> cycle+2 wdata_WB=16'hBEEF.
- REQ-033: rd_Ex=0, WB_Ex=1 -> WB_MM=0, WB_WB=0, retire_cnt unchanged.
- REQ-034: stall=1 for 3 cycles with flush_Ex=1 -> all outputs frozen; then flush_Ex=1, stall=0 -> WB_MM=0 next cycle.
- REQ-035: With LOAD_USE_DET_EN, load rd_Ex=2, rs_Id=2 -> load_use_hz=1; rs_Id=4, rt_Id=1 -> 0.
